// File: rtl/spi_xip_sequencer_if.sv
// Bus bundle for the XIP sequencer: APB port from the interconnect plus the
// Wishbone register port toward the SPI master.
interface spi_xip_sequencer_if;
    logic [31:0] in_paddr;
    logic        in_psel;
    logic        in_penable;
    logic        in_pwrite;
    logic [31:0] in_pwdata;
    logic [3:0]  in_pstrb;
    logic        in_pready;
    logic [31:0] in_prdata;
    logic        in_pslverr;

    logic [4:0]  wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o;
    logic        wb_stb_o;
    logic        wb_cyc_o;
    logic        wb_ack_i;
    logic        wb_err_i;

    // Sequencer view: APB completer, Wishbone initiator.
    modport slave (
        input  in_paddr, in_psel, in_penable, in_pwrite, in_pwdata, in_pstrb,
        output in_pready, in_prdata, in_pslverr,
        output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_stb_o, wb_cyc_o,
        input  wb_dat_i, wb_ack_i, wb_err_i
    );

    // Environment view: APB requester and SPI master register file.
    modport master (
        output in_paddr, in_psel, in_penable, in_pwrite, in_pwdata, in_pstrb,
        input  in_pready, in_prdata, in_pslverr,
        input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_stb_o, wb_cyc_o,
        output wb_dat_i, wb_ack_i, wb_err_i
    );
endinterface

// File: rtl/spi_xip_sequencer.sv
// APB front end sharing the SPI master's Wishbone port between direct register
// access and execute-in-place flash reads run as full SPI programming sequences.
module spi_xip_sequencer #(
    parameter logic [31:0] FLASH_BASE  = 32'h3000_0000,
    parameter logic [31:0] FLASH_END   = 32'h3fff_ffff,
    parameter logic [31:0] SPI_BASE    = 32'h1000_1000,
    parameter logic [31:0] SPI_END     = 32'h1000_1fff,
    parameter logic [31:0] DIVIDER_VAL = 32'h1,
    parameter logic [7:0]  SS_MASK     = 8'h01,
    parameter logic [15:0] POLL_MAX    = 16'd1024
) (
    input  logic                      clock,
    input  logic                      reset,
    spi_xip_sequencer_if.slave        bus,
    output logic                      xip_busy
);
    localparam logic [4:0] OFS_DATA = 5'h00;
    localparam logic [4:0] OFS_TX1  = 5'h04;
    localparam logic [4:0] OFS_CTRL = 5'h10;
    localparam logic [4:0] OFS_DIV  = 5'h14;
    localparam logic [4:0] OFS_SS   = 5'h18;
    localparam int         GO_BSY   = 8;

    typedef enum logic [3:0] {
        IDLE, DIRECT, X_TX0, X_TX1, X_DIV, X_SS, X_GO, X_POLL, X_RX, X_SSCLR, RESP
    } state_t;

    typedef struct packed {
        logic [4:0]  adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        we;
    } wb_op_t;

    state_t      state;
    logic        error;
    logic [15:0] poll_cnt;
    logic [31:0] result;
    wb_op_t      op;
    logic        in_spi;
    logic        in_flash;
    logic        fail_now;

    // Wishbone operation each state issues; held stable while cyc is high
    // because the state and the live APB inputs do not change until ack.
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        op       = '{adr: OFS_DATA, dat: 32'h0, sel: 4'hF, we: 1'b1};
        in_spi   = (bus.in_paddr >= SPI_BASE) && (bus.in_paddr <= SPI_END);
        in_flash = (bus.in_paddr >= FLASH_BASE) && (bus.in_paddr <= FLASH_END);
        fail_now = error | bus.wb_err_i;
        case (state)
            DIRECT:  op = '{adr: bus.in_paddr[4:0], dat: bus.in_pwdata,
                            sel: bus.in_pstrb, we: bus.in_pwrite};
            X_TX1:   begin op.adr = OFS_TX1;  op.dat = {8'h03, bus.in_paddr[23:0]}; end
            X_DIV:   begin op.adr = OFS_DIV;  op.dat = DIVIDER_VAL; end
            X_SS:    begin op.adr = OFS_SS;   op.dat = {24'b0, SS_MASK}; end
            X_GO:    begin op.adr = OFS_CTRL; op.dat = 32'h0000_0140; end
            X_POLL:  begin op.adr = OFS_CTRL; op.we = 1'b0; end
            X_RX:    begin op.adr = OFS_DATA; op.we = 1'b0; end
            X_SSCLR: op.adr = OFS_SS;
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            error          <= 1'b0;
            poll_cnt       <= 16'd0;
            result         <= 32'h0;
            xip_busy       <= 1'b0;
            bus.in_pready  <= 1'b0;
            bus.in_prdata  <= 32'h0;
            bus.in_pslverr <= 1'b0;
            bus.wb_adr_o   <= 5'h0;
            bus.wb_dat_o   <= 32'h0;
            bus.wb_sel_o   <= 4'h0;
            bus.wb_we_o    <= 1'b0;
            bus.wb_stb_o   <= 1'b0;
            bus.wb_cyc_o   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            case (state)
                IDLE: begin
                    if (bus.in_psel && bus.in_penable) begin
                        if (in_spi) begin
                            state <= DIRECT;
                        end else if (in_flash && !bus.in_pwrite) begin
                            state    <= X_TX0;
                            xip_busy <= 1'b1;
                        end else begin
                            bus.in_pready  <= 1'b1;
                            bus.in_prdata  <= 32'h0;
                            bus.in_pslverr <= 1'b1;
                            state          <= RESP;
                        end
                    end
                end

                RESP: begin
                    bus.in_pready  <= 1'b0;
                    bus.in_prdata  <= 32'h0;
                    bus.in_pslverr <= 1'b0;
                    error          <= 1'b0;
                    poll_cnt       <= 16'd0;
                    state          <= IDLE;
                end

                DIRECT, X_TX0, X_TX1, X_DIV, X_SS, X_GO, X_POLL, X_RX, X_SSCLR: begin
                    if (!bus.wb_cyc_o) begin
                        // Launch; reaching here only after a cycle with cyc low.
                        bus.wb_cyc_o <= 1'b1;
                        bus.wb_stb_o <= 1'b1;
                        bus.wb_adr_o <= op.adr;
                        bus.wb_dat_o <= op.dat;
                        bus.wb_sel_o <= op.sel;
                        bus.wb_we_o  <= op.we;
                    end else if (bus.wb_ack_i || bus.wb_err_i) begin
                        bus.wb_cyc_o <= 1'b0;
                        bus.wb_stb_o <= 1'b0;
                        if (state == DIRECT) begin
                            bus.in_pready  <= 1'b1;
                            bus.in_prdata  <= bus.wb_err_i ? 32'h0 : bus.wb_dat_i;
                            bus.in_pslverr <= bus.wb_err_i;
                            state          <= RESP;
                        end else if (state == X_SSCLR) begin
                            bus.in_pready  <= 1'b1;
                            bus.in_prdata  <= fail_now ? 32'h0 : result;
                            bus.in_pslverr <= fail_now;
                            xip_busy       <= 1'b0;
                            state          <= RESP;
                        end else if (bus.wb_err_i) begin
                            error <= 1'b1;
                            state <= X_SSCLR;
                        end else begin
                            case (state)
                                X_TX0: state <= X_TX1;
                                X_TX1: state <= X_DIV;
                                X_DIV: state <= X_SS;
                                X_SS:  state <= X_GO;
                                X_GO:  state <= X_POLL;
                                X_POLL: begin
                                    if (!bus.wb_dat_i[GO_BSY]) begin
                                        state <= X_RX;
                                    end else begin
                                        poll_cnt <= poll_cnt + 16'd1;
                                        if (poll_cnt + 16'd1 == POLL_MAX) begin
                                            error <= 1'b1;
                                            state <= X_SSCLR;
                                        end
                                    end
                                end
                                X_RX: begin
                                    // Flash streams big-endian; present it little-endian.
                                    result <= {bus.wb_dat_i[7:0], bus.wb_dat_i[15:8],
                                               bus.wb_dat_i[23:16], bus.wb_dat_i[31:24]};
                                    state  <= X_SSCLR;
                                end
                                default: state <= IDLE;
                            endcase
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule
